memory_xy_drive_sequencer: RTL and testbench

MEMORY_XY_DRIVE_SEQUENCER -- requirements
Module: memory_xy_drive_sequencer

---
 rtl/lvdc_mem_pkg.sv | 23 ++
 rtl/onehot_n_encode.sv | 22 ++
 rtl/memory_xy_drive_sequencer.sv | 147 ++++++++++++++
 tb/tb_memory_xy_drive_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lvdc_mem_pkg.sv
// Shared state encoding and default phase lengths for the core-memory XY drive sequencer.
package lvdc_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_READ  = 3'd2,
        ST_SENSE = 3'd3,
        ST_WRT   = 3'd4,
        ST_RECOV = 3'd5
    } state_t;

    localparam int DEF_READ_CYC  = 4;
    localparam int DEF_SNS_CYC   = 1;
    localparam int DEF_WRITE_CYC = 4;
    localparam int DEF_REC_CYC   = 2;

    // Phase counters count down to zero, so a phase of N clocks loads N-1.
    function automatic logic [3:0] phase_load(input int cyc);
        return 4'(cyc - 1);
    endfunction

endpackage

// File: rtl/onehot_n_encode.sv
// Checks an active-low one-hot decode for exactly one low bit and encodes its position.
module onehot_n_encode (
    input  logic [7:0] sel_n,
    output logic       valid,
    output logic [2:0] idx
);

    logic [3:0] lows;

    always_comb begin
        lows = 4'd0;
        idx  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!sel_n[i]) begin
                lows = lows + 4'd1;
                idx  = 3'(i);
            end
        end
        valid = (lows == 4'd1);
    end

endmodule

// File: rtl/memory_xy_drive_sequencer.sv
// Core-memory cycle sequencer: latch XY address, read-drive, sense, write/inhibit, recover.
// All outputs registered; reset drops every drive asynchronously.
module memory_xy_drive_sequencer
    import lvdc_mem_pkg::*;
#(
    parameter int READ_CYC  = DEF_READ_CYC,
    parameter int SNS_CYC   = DEF_SNS_CYC,
    parameter int WRITE_CYC = DEF_WRITE_CYC,
    parameter int REC_CYC   = DEF_REC_CYC
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       WRITE,
    input  logic       WDATA,
    input  logic [7:0] AXN,
    input  logic [7:0] AXTN,
    input  logic [7:0] AYN,
    input  logic       RDATA,
    output logic [5:0] XSEL,
    output logic [2:0] YSEL,
    output logic       XDRV,
    output logic       YDRV,
    output logic       SNS,
    output logic       XWR,
    output logic       YWR,
    output logic       INH,
    output logic       RDAT,
    output logic       BUSY,
    output logic       DONE,
    output logic       DERR
);

    state_t     state;
    logic [3:0] cnt;
    logic       wr_lat;
    logic       wd_lat;
    logic       err_pend;

    logic       xu_vld, xt_vld, y_vld;
    logic [2:0] xu_idx, xt_idx, y_idx;

    onehot_n_encode u_dec_xu (.sel_n(AXN),  .valid(xu_vld), .idx(xu_idx));
    onehot_n_encode u_dec_xt (.sel_n(AXTN), .valid(xt_vld), .idx(xt_idx));
    onehot_n_encode u_dec_y  (.sel_n(AYN),  .valid(y_vld),  .idx(y_idx));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            wr_lat   <= 1'b0;
            wd_lat   <= 1'b0;
            err_pend <= 1'b0;
            XSEL     <= 6'd0;
            YSEL     <= 3'd0;
            XDRV     <= 1'b0;
            YDRV     <= 1'b0;
            SNS      <= 1'b0;
            XWR      <= 1'b0;
            YWR      <= 1'b0;
            INH      <= 1'b0;
            RDAT     <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            DERR     <= 1'b0;
        end else begin
            // An aborted cycle reports DONE one clock after it has already dropped BUSY.
            DONE     <= err_pend;
            err_pend <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state <= ST_LATCH;
                        BUSY  <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    XSEL   <= {xt_idx, xu_idx};
                    YSEL   <= y_idx;
                    wr_lat <= WRITE;
                    wd_lat <= WDATA;
                    DERR   <= !(xu_vld && xt_vld && y_vld);
                    if (xu_vld && xt_vld && y_vld) begin
                        state <= ST_READ;
                        cnt   <= phase_load(READ_CYC);
                        XDRV  <= 1'b1;
                        YDRV  <= 1'b1;
                    end else begin
                        state    <= ST_IDLE;
                        BUSY     <= 1'b0;
                        err_pend <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (cnt == 4'd0) begin
                        state <= ST_SENSE;
                        cnt   <= phase_load(SNS_CYC);
                        XDRV  <= 1'b0;
                        YDRV  <= 1'b0;
                        SNS   <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_SENSE: begin
                    if (cnt == 4'd0) begin
                        state <= ST_WRT;
                        cnt   <= phase_load(WRITE_CYC);
                        SNS   <= 1'b0;
                        RDAT  <= RDATA;
                        XWR   <= 1'b1;
                        YWR   <= 1'b1;
                        // RDAT loads on this same edge, so restore uses RDATA directly.
                        INH   <= wr_lat ? !wd_lat : !RDATA;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_WRT: begin
                    if (cnt == 4'd0) begin
                        state <= ST_RECOV;
                        cnt   <= phase_load(REC_CYC);
                        XWR   <= 1'b0;
                        YWR   <= 1'b0;
                        INH   <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RECOV: begin
                    if (cnt == 4'd0) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_xy_drive_sequencer.sv
// Directed bench for the XY drive sequencer; per-clock output traces checked against hand timelines.
module tb_memory_xy_drive_sequencer;

    logic       CLK, RESET, START, WRITE, WDATA, RDATA;
    logic [7:0] AXN, AXTN, AYN;
    logic [5:0] XSEL;
    logic [2:0] YSEL;
    logic       XDRV, YDRV, SNS, XWR, YWR, INH, RDAT, BUSY, DONE, DERR;

    int checks = 0;
    int errors = 0;

    memory_xy_drive_sequencer dut (
        .CLK(CLK), .RESET(RESET), .START(START), .WRITE(WRITE), .WDATA(WDATA),
        .AXN(AXN), .AXTN(AXTN), .AYN(AYN), .RDATA(RDATA),
        .XSEL(XSEL), .YSEL(YSEL), .XDRV(XDRV), .YDRV(YDRV), .SNS(SNS),
        .XWR(XWR), .YWR(YWR), .INH(INH), .RDAT(RDAT), .BUSY(BUSY),
        .DONE(DONE), .DERR(DERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Trace k holds outputs sampled at the falling edge after rising edge k; edge 0 samples START.
    logic [5:0] xsel_a [0:31];
    logic [2:0] ysel_a [0:31];
    logic       rdat_a [0:31];
    logic       done_a [0:31];
    logic       busy_a [0:31];
    logic       derr_a [0:31];
    logic       inh_a  [0:31];
    int cnt_xdrv, first_xdrv, cnt_ydrv, cnt_sns, first_sns, cnt_xwr, first_xwr, cnt_ywr;
    int cnt_inh, first_inh, cnt_done, first_done, cnt_busy, overlap, inh_out;

    task automatic capture(input int n, input bit hold_start, input int pulse_at);
        cnt_xdrv = 0; first_xdrv = -1; cnt_ydrv = 0; cnt_sns = 0; first_sns = -1;
        cnt_xwr = 0; first_xwr = -1; cnt_ywr = 0; cnt_inh = 0; first_inh = -1;
        cnt_done = 0; first_done = -1; cnt_busy = 0; overlap = 0; inh_out = 0;
        @(posedge CLK);
        if (!hold_start) begin
            #1 START = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            xsel_a[k] = XSEL; ysel_a[k] = YSEL; rdat_a[k] = RDAT;
            done_a[k] = DONE; busy_a[k] = BUSY; derr_a[k] = DERR; inh_a[k] = INH;
            if (XDRV === 1'b1) begin cnt_xdrv++; if (first_xdrv < 0) first_xdrv = k; end
            if (YDRV === 1'b1) cnt_ydrv++;
            if (SNS  === 1'b1) begin cnt_sns++;  if (first_sns < 0) first_sns = k; end
            if (XWR  === 1'b1) begin cnt_xwr++;  if (first_xwr < 0) first_xwr = k; end
            if (YWR  === 1'b1) cnt_ywr++;
            if (INH  === 1'b1) begin cnt_inh++;  if (first_inh < 0) first_inh = k; end
            if (DONE === 1'b1) begin cnt_done++; if (first_done < 0) first_done = k; end
            if (BUSY === 1'b1) cnt_busy++;
            if ((XDRV | YDRV) & (XWR | YWR)) overlap++;
            if (INH & !XWR) inh_out++;
            if (!hold_start) START = (k == pulse_at);
            if (k < n - 1) @(posedge CLK);
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1; START = 1'b0; WRITE = 1'b0; WDATA = 1'b0; RDATA = 1'b0;
        AXN = 8'hFF; AXTN = 8'hFF; AYN = 8'hFF;
        #3;
        checks++;
        if ({XSEL, YSEL, XDRV, YDRV, SNS, XWR, YWR, INH, RDAT, BUSY, DONE, DERR} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {XSEL, YSEL, XDRV, YDRV, SNS, XWR, YWR, INH, RDAT, BUSY, DONE, DERR});
        end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_read_restore(input logic rdata_v);
        AXN = ~8'h04; AXTN = ~8'h08; AYN = ~8'h02; WRITE = 1'b0; WDATA = 1'b1; RDATA = rdata_v;
        START = 1'b1;
        capture(14, 1'b0, -1);
        checks++;
        if (xsel_a[12] !== 6'd26 || ysel_a[12] !== 3'd1) begin
            errors++; $display("FAIL rr_addr: xsel=%0d ysel=%0d want 26/1", xsel_a[12], ysel_a[12]);
        end
        checks++;
        if (cnt_xdrv != 4 || cnt_ydrv != 4 || first_xdrv != 1) begin
            errors++; $display("FAIL rr_read_drive: x=%0d y=%0d first=%0d want 4/4/1", cnt_xdrv, cnt_ydrv, first_xdrv);
        end
        checks++;
        if (cnt_sns != 1 || first_sns != 5) begin
            errors++; $display("FAIL rr_sense: cnt=%0d first=%0d want 1/5", cnt_sns, first_sns);
        end
        checks++;
        if (rdat_a[6] !== rdata_v) begin
            errors++; $display("FAIL rr_rdat: got %b want %b", rdat_a[6], rdata_v);
        end
        checks++;
        if (cnt_xwr != 4 || cnt_ywr != 4 || first_xwr != 6) begin
            errors++; $display("FAIL rr_write_drive: x=%0d y=%0d first=%0d want 4/4/6", cnt_xwr, cnt_ywr, first_xwr);
        end
        checks++;
        if (cnt_inh != (rdata_v ? 0 : 4) || inh_out != 0) begin
            errors++; $display("FAIL rr_inhibit: cnt=%0d outside=%0d want %0d/0", cnt_inh, inh_out, rdata_v ? 0 : 4);
        end
        checks++;
        if (cnt_done != 1 || first_done != 12 || cnt_busy != 12 || busy_a[12] !== 1'b0) begin
            errors++; $display("FAIL rr_done: done=%0d at %0d busy=%0d want 1 at 12, busy 12", cnt_done, first_done, cnt_busy);
        end
        checks++;
        if (overlap != 0 || derr_a[1] !== 1'b0) begin
            errors++; $display("FAIL rr_exclusive: overlap=%0d derr=%b want 0/0", overlap, derr_a[1]);
        end
    endtask

    task automatic test_write(input logic wd, input logic rd);
        AXN = ~8'h80; AXTN = ~8'h01; AYN = ~8'h80; WRITE = 1'b1; WDATA = wd; RDATA = rd;
        START = 1'b1;
        capture(14, 1'b0, -1);
        checks++;
        if (xsel_a[12] !== 6'd7 || ysel_a[12] !== 3'd7) begin
            errors++; $display("FAIL wr_addr: xsel=%0d ysel=%0d want 7/7", xsel_a[12], ysel_a[12]);
        end
        checks++;
        if (cnt_inh != (wd ? 0 : 4) || (!wd && first_inh != 6) || inh_out != 0) begin
            errors++; $display("FAIL wr_inhibit: cnt=%0d first=%0d want %0d", cnt_inh, first_inh, wd ? 0 : 4);
        end
        checks++;
        if (cnt_xwr != 4 || cnt_ywr != 4 || cnt_xdrv != 4 || overlap != 0) begin
            errors++; $display("FAIL wr_drives: xwr=%0d ywr=%0d xdrv=%0d ovl=%0d want 4/4/4/0", cnt_xwr, cnt_ywr, cnt_xdrv, overlap);
        end
        checks++;
        if (cnt_done != 1 || first_done != 12) begin
            errors++; $display("FAIL wr_done: cnt=%0d at %0d want 1 at 12", cnt_done, first_done);
        end
    endtask

    task automatic test_decode_error(input logic [7:0] axn_v, input logic [7:0] ayn_v);
        AXN = axn_v; AXTN = ~8'h01; AYN = ayn_v; WRITE = 1'b1; WDATA = 1'b0; RDATA = 1'b0;
        START = 1'b1;
        capture(6, 1'b0, -1);
        checks++;
        if (derr_a[1] !== 1'b1 || derr_a[5] !== 1'b1) begin
            errors++; $display("FAIL derr_flag: k1=%b k5=%b want 1/1", derr_a[1], derr_a[5]);
        end
        checks++;
        if (cnt_xdrv + cnt_ydrv + cnt_sns + cnt_xwr + cnt_ywr + cnt_inh != 0) begin
            errors++; $display("FAIL derr_drives: %0d drive clocks want 0",
                               cnt_xdrv + cnt_ydrv + cnt_sns + cnt_xwr + cnt_ywr + cnt_inh);
        end
        checks++;
        if (cnt_busy != 1 || busy_a[0] !== 1'b1 || cnt_done != 1 || first_done != 2) begin
            errors++; $display("FAIL derr_timing: busy=%0d done=%0d at %0d want 1, 1 at 2", cnt_busy, cnt_done, first_done);
        end
    endtask

    task automatic test_back_to_back;
        AXN = ~8'h01; AXTN = ~8'h02; AYN = ~8'h04; WRITE = 1'b0; RDATA = 1'b1;
        START = 1'b1;
        capture(27, 1'b1, -1);
        checks++;
        if (cnt_done != 2 || first_done != 12 || done_a[25] !== 1'b1 || derr_a[13] !== 1'b0) begin
            errors++; $display("FAIL b2b_done: cnt=%0d first=%0d second=%b want 2/12/1", cnt_done, first_done, done_a[25]);
        end
        checks++;
        if (busy_a[12] !== 1'b0 || busy_a[13] !== 1'b1 || cnt_busy != 25) begin
            errors++; $display("FAIL b2b_gap: k12=%b k13=%b busy=%0d want 0/1/25", busy_a[12], busy_a[13], cnt_busy);
        end
        START = 1'b0;
        repeat (16) @(posedge CLK);
        @(negedge CLK);
        START = 1'b1;
        capture(20, 1'b0, 5);
        checks++;
        if (cnt_done != 1 || first_done != 12 || cnt_busy != 12) begin
            errors++; $display("FAIL busy_start_ignored: done=%0d at %0d busy=%0d want 1 at 12, 12", cnt_done, first_done, cnt_busy);
        end
    endtask

    task automatic test_reset_mid_read;
        AXN = ~8'h02; AXTN = ~8'h04; AYN = ~8'h08; WRITE = 1'b0; RDATA = 1'b1;
        START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (XDRV !== 1'b1 || YDRV !== 1'b1) begin
            errors++; $display("FAIL mid_read_active: xdrv=%b ydrv=%b want 1/1", XDRV, YDRV);
        end
        #2 RESET = 1'b1;
        #1;
        checks++;
        if ({XDRV, YDRV, BUSY, XSEL, DERR} !== 10'd0) begin
            errors++; $display("FAIL async_reset_drop: xdrv=%b ydrv=%b busy=%b xsel=%0d want 0", XDRV, YDRV, BUSY, XSEL);
        end
        @(negedge CLK);
        RESET = 1'b0;
        capture(14, 1'b0, -1);
        checks++;
        if (cnt_done != 0 || cnt_busy != 0 || cnt_xdrv != 0) begin
            errors++; $display("FAIL reset_no_done: done=%0d busy=%0d xdrv=%0d want 0/0/0", cnt_done, cnt_busy, cnt_xdrv);
        end
        START = 1'b1;
        capture(14, 1'b0, -1);
        checks++;
        if (cnt_done != 1 || first_done != 12 || xsel_a[12] !== 6'd17 || ysel_a[12] !== 3'd3) begin
            errors++; $display("FAIL after_reset_cycle: done=%0d at %0d xsel=%0d ysel=%0d want 1 at 12, 17/3",
                               cnt_done, first_done, xsel_a[12], ysel_a[12]);
        end
    endtask

    initial begin
        test_reset();
        test_read_restore(1'b1);
        test_read_restore(1'b0);
        test_write(1'b0, 1'b1);
        test_write(1'b1, 1'b0);
        test_decode_error(~8'h01, 8'hFF);
        test_decode_error(~8'h03, ~8'h01);
        test_read_restore(1'b1);
        test_back_to_back();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
